// File: rtl/mem_pkg.sv
// Shared definitions for the parametrised dual-port memory and its clear sequencer.
package mem_pkg;

    localparam int unsigned COLL_READ_PRIO   = 0;
    localparam int unsigned COLL_WRITE_FIRST = 1;
    localparam int unsigned COLL_READ_FIRST  = 2;

    typedef enum logic {
        ST_CLEAR = 1'b0,
        ST_RUN   = 1'b1
    } state_t;

    // True when an address falls inside the populated part of the array.
    function automatic logic addr_in_range(input int unsigned addr, input int unsigned depth);
        return addr < depth;
    endfunction

endpackage

// File: rtl/mem_clear_seq.sv
// Clear sequencer: walks every word of the array writing zero after reset or on request.
module mem_clear_seq
    import mem_pkg::*;
#(
    parameter int unsigned ADDR_W = 7,
    parameter int unsigned DEPTH  = 128
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clr,
    output logic              busy,
    output logic              clr_we,
    output logic [ADDR_W-1:0] clr_addr
);

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

    state_t            state;
    state_t            state_d;
    logic [ADDR_W-1:0] cnt;
    logic [ADDR_W-1:0] cnt_d;
    logic              busy_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_CLEAR;
            cnt   <= '0;
            busy  <= 1'b1;
        end else begin
            state <= state_d;
            cnt   <= cnt_d;
            busy  <= busy_d;
        end
    end

    always_comb begin
        state_d = state;
        cnt_d   = cnt;
        busy_d  = busy;
        case (state)
            ST_CLEAR: begin
                // Terminate on the last populated word, not on counter wrap.
                if (cnt == LAST_ADDR) begin
                    state_d = ST_RUN;
                    cnt_d   = '0;
                    busy_d  = 1'b0;
                end else begin
                    cnt_d = cnt + ADDR_W'(1);
                end
            end
            ST_RUN: begin
                if (clr) begin
                    state_d = ST_CLEAR;
                    cnt_d   = '0;
                    busy_d  = 1'b1;
                end
            end
            default: begin
                state_d = ST_CLEAR;
                cnt_d   = '0;
                busy_d  = 1'b1;
            end
        endcase
    end

    assign clr_we   = (state == ST_CLEAR);
    assign clr_addr = cnt;

endmodule

// File: rtl/param_dp_memory.sv
// Parametrised one-read/one-write memory with selectable read latency,
// same-address collision policy and a built-in clear sequencer.
module param_dp_memory
    import mem_pkg::*;
#(
    parameter int unsigned DATA_W    = 8,
    parameter int unsigned ADDR_W    = 7,
    parameter int unsigned DEPTH     = 128,
    parameter int unsigned RD_LAT    = 1,
    parameter int unsigned COLL_MODE = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clr,
    output logic              busy,
    input  logic              ren,
    input  logic [ADDR_W-1:0] raddr,
    input  logic              wen,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] din,
    output logic [DATA_W-1:0] dout,
    output logic              dout_valid,
    output logic              wr_drop
);

    localparam int unsigned IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [DATA_W-1:0] mem [DEPTH];

    logic              clr_we;
    logic [ADDR_W-1:0] clr_addr;

    mem_clear_seq #(
        .ADDR_W (ADDR_W),
        .DEPTH  (DEPTH)
    ) u_clear_seq (
        .clk      (clk),
        .rst      (rst),
        .clr      (clr),
        .busy     (busy),
        .clr_we   (clr_we),
        .clr_addr (clr_addr)
    );

    logic              run;
    logic              rd_acc;
    logic              r_ok;
    logic              w_ok;
    logic              coll;
    logic              wr_acc;
    logic              drop_d;
    logic              flush;
    logic [DATA_W-1:0] rd_word;

    assign run    = ~busy;
    assign rd_acc = run & ren & ~clr;
    assign r_ok   = addr_in_range(32'(raddr), DEPTH);
    assign w_ok   = addr_in_range(32'(waddr), DEPTH);
    assign coll   = rd_acc & wen & r_ok & (raddr == waddr);
    assign wr_acc = wen & run & w_ok & ~(coll & (COLL_MODE == COLL_READ_PRIO));
    assign drop_d = wen & ~wr_acc;
    assign flush  = run & clr;

    // Array read with range guard and write-first bypass on collision.
    always_comb begin
        rd_word = '0;
        if (r_ok) begin
            rd_word = mem[raddr[IDX_W-1:0]];
        end
        if (coll && (COLL_MODE == COLL_WRITE_FIRST)) begin
            rd_word = din;
        end
    end

    // Storage has no reset; the clear sequencer owns initialisation.
    always_ff @(posedge clk) begin
        if (!rst) begin
            if (clr_we) begin
                mem[clr_addr[IDX_W-1:0]] <= '0;
            end else if (wr_acc) begin
                mem[waddr[IDX_W-1:0]] <= din;
            end
        end
    end

    logic              s1_valid;
    logic [DATA_W-1:0] s1_data;

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            s1_valid <= 1'b0;
            s1_data  <= '0;
        end else begin
            s1_valid <= rd_acc;
            s1_data  <= rd_acc ? rd_word : '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_drop <= 1'b0;
        end else begin
            wr_drop <= drop_d;
        end
    end

    generate
        if (RD_LAT == 2) begin : g_lat2
            logic              s2_valid;
            logic [DATA_W-1:0] s2_data;

            // Extra output stage; collision result was already fixed in stage one.
            always_ff @(posedge clk) begin
                if (rst || flush) begin
                    s2_valid <= 1'b0;
                    s2_data  <= '0;
                end else begin
                    s2_valid <= s1_valid;
                    s2_data  <= s1_data;
                end
            end

            assign dout_valid = s2_valid;
            assign dout       = s2_data;
        end else begin : g_lat1
            assign dout_valid = s1_valid;
            assign dout       = s1_data;
        end
    endgenerate

endmodule

// File: tb/tb_param_dp_memory.sv
// Randomised bench for param_dp_memory: three configurations share one stimulus
// stream and are compared every cycle against a behavioural model.
module tb_param_dp_memory;

    logic       clk = 1'b0;
    logic       rst;
    logic       clr;
    logic       ren;
    logic [6:0] raddr;
    logic       wen;
    logic [6:0] waddr;
    logic [7:0] din;

    logic       busy_o  [3];
    logic [7:0] dout_o  [3];
    logic       valid_o [3];
    logic       drop_o  [3];

    int unsigned dep_c  [3] = '{128, 128, 100};
    int unsigned lat_c  [3] = '{1, 2, 1};
    int unsigned mode_c [3] = '{0, 1, 2};

    int n_tests = 0;
    int n_fail  = 0;
    bit chk_en  = 1'b0;

    always #5 clk = ~clk;

    param_dp_memory #(.DATA_W(8), .ADDR_W(7), .DEPTH(128), .RD_LAT(1), .COLL_MODE(0)) u0 (
        .clk(clk), .rst(rst), .clr(clr), .busy(busy_o[0]), .ren(ren), .raddr(raddr),
        .wen(wen), .waddr(waddr), .din(din), .dout(dout_o[0]), .dout_valid(valid_o[0]),
        .wr_drop(drop_o[0]));

    param_dp_memory #(.DATA_W(8), .ADDR_W(7), .DEPTH(128), .RD_LAT(2), .COLL_MODE(1)) u1 (
        .clk(clk), .rst(rst), .clr(clr), .busy(busy_o[1]), .ren(ren), .raddr(raddr),
        .wen(wen), .waddr(waddr), .din(din), .dout(dout_o[1]), .dout_valid(valid_o[1]),
        .wr_drop(drop_o[1]));

    param_dp_memory #(.DATA_W(8), .ADDR_W(7), .DEPTH(100), .RD_LAT(1), .COLL_MODE(2)) u2 (
        .clk(clk), .rst(rst), .clr(clr), .busy(busy_o[2]), .ren(ren), .raddr(raddr),
        .wen(wen), .waddr(waddr), .din(din), .dout(dout_o[2]), .dout_valid(valid_o[2]),
        .wr_drop(drop_o[2]));

    // Reference state per configuration.
    int unsigned mem_m  [3][128];
    int unsigned cnt_m  [3];
    bit          busy_m [3];
    bit          s1v_m  [3];
    int unsigned s1d_m  [3];
    bit          ov_m   [3];
    int unsigned od_m   [3];
    bit          drop_m [3];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Advance the model by one clock edge using the inputs currently applied.
    task automatic model_step();
        for (int k = 0; k < 3; k++) begin
            bit run, rd_ok, r_in, w_in, coll, wr_ok, rv, flush;
            int unsigned rd;
            if (rst) begin
                busy_m[k] = 1; cnt_m[k] = 0; s1v_m[k] = 0; s1d_m[k] = 0;
                ov_m[k] = 0; od_m[k] = 0; drop_m[k] = 0;
                continue;
            end
            run   = !busy_m[k];
            rd_ok = run && ren && !clr;
            r_in  = raddr < dep_c[k];
            w_in  = waddr < dep_c[k];
            coll  = rd_ok && wen && r_in && (raddr == waddr);
            wr_ok = wen && run && w_in && !(coll && mode_c[k] == 0);
            drop_m[k] = wen && !wr_ok;
            rv = rd_ok;
            rd = 0;
            if (rd_ok && r_in) rd = (coll && mode_c[k] == 1) ? din : mem_m[k][raddr];
            if (!run) begin
                mem_m[k][cnt_m[k]] = 0;
                cnt_m[k]++;
                if (cnt_m[k] == dep_c[k]) busy_m[k] = 0;
            end else if (wr_ok) begin
                mem_m[k][waddr] = din;
            end
            flush = run && clr;
            if (flush) begin busy_m[k] = 1; cnt_m[k] = 0; end
            if (lat_c[k] == 1) begin
                ov_m[k] = rv; od_m[k] = rd;
            end else begin
                ov_m[k] = s1v_m[k]; od_m[k] = s1d_m[k];
                s1v_m[k] = rv; s1d_m[k] = rd;
            end
            if (flush) begin ov_m[k] = 0; od_m[k] = 0; s1v_m[k] = 0; s1d_m[k] = 0; end
        end
    endtask

    task automatic compare_all();
        for (int k = 0; k < 3; k++) begin
            check($sformatf("u%0d.busy", k),       32'(busy_o[k]),  32'(busy_m[k]));
            check($sformatf("u%0d.dout_valid", k), 32'(valid_o[k]), 32'(ov_m[k]));
            check($sformatf("u%0d.dout", k),       32'(dout_o[k]),  od_m[k]);
            check($sformatf("u%0d.wr_drop", k),    32'(drop_o[k]),  32'(drop_m[k]));
        end
    endtask

    task automatic tick();
        model_step();
        @(negedge clk);
        if (chk_en) compare_all();
    endtask

    task automatic idle();
        ren = 0; wen = 0; clr = 0; rst = 0;
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 300 && (busy_o[0] || busy_o[1] || busy_o[2]); i++) tick();
        check("idle_wait", 32'(busy_o[0] | busy_o[1] | busy_o[2]), 32'd0);
    endtask

    int n0, n2;

    initial begin
        rst = 1; clr = 0; ren = 0; wen = 0; raddr = 0; waddr = 0; din = 0;
        tick();
        chk_en = 1;
        tick();
        rst = 0;

        // Post-reset clear length.
        n0 = 0; n2 = 0;
        for (int i = 0; i < 300 && (busy_o[0] || busy_o[2]); i++) begin
            if (busy_o[0]) n0++;
            if (busy_o[2]) n2++;
            tick();
        end
        check("busy_len_d128", 32'(n0), 32'd128);
        check("busy_len_d100", 32'(n2), 32'd100);
        wait_idle();

        ren = 1; raddr = 7'h05; tick();
        check("rd_after_clear_data", 32'(dout_o[0]), 32'h00);
        check("rd_after_clear_valid", 32'(valid_o[0]), 32'd1);
        idle();

        // Write then read back, then idle zero.
        wen = 1; waddr = 7'h10; din = 8'h5A; tick();
        wen = 0; ren = 1; raddr = 7'h10; tick();
        check("wr_rd_5a", 32'(dout_o[0]), 32'h5A);
        ren = 0; tick();
        check("idle_dout", 32'(dout_o[0]), 32'h00);
        check("idle_valid", 32'(valid_o[0]), 32'd0);

        // Same-address collision under each policy.
        wen = 1; waddr = 7'h20; din = 8'h11; tick();
        ren = 1; raddr = 7'h20; din = 8'h22; tick();
        check("coll_rp_dout", 32'(dout_o[0]), 32'h11);
        check("coll_rp_drop", 32'(drop_o[0]), 32'd1);
        check("coll_rf_dout", 32'(dout_o[2]), 32'h11);
        check("coll_rf_drop", 32'(drop_o[2]), 32'd0);
        idle(); tick();
        check("coll_wf_dout", 32'(dout_o[1]), 32'h22);
        ren = 1; raddr = 7'h20; tick();
        check("reread_rp", 32'(dout_o[0]), 32'h11);
        check("reread_rf", 32'(dout_o[2]), 32'h22);
        idle(); tick();
        check("reread_wf", 32'(dout_o[1]), 32'h22);

        // Address beyond DEPTH=100.
        wen = 1; waddr = 7'h70; din = 8'h33; tick();
        check("oor_wr_drop", 32'(drop_o[2]), 32'd1);
        check("inr_wr_nodrop", 32'(drop_o[0]), 32'd0);
        wen = 0; ren = 1; raddr = 7'h70; tick();
        check("oor_rd_data", 32'(dout_o[2]), 32'h00);
        check("oor_rd_valid", 32'(valid_o[2]), 32'd1);
        check("inr_rd_data", 32'(dout_o[0]), 32'h33);
        idle();

        // Clear on request with a write attempted while busy.
        clr = 1; tick(); clr = 0;
        n0 = 0;
        for (int i = 0; i < 300 && busy_o[0]; i++) begin
            wen = (n0 == 5); waddr = 7'h30; din = 8'h44;
            tick();
            n0++;
            if (n0 == 6) check("busy_wr_drop", 32'(drop_o[0]), 32'd1);
        end
        check("clr_busy_len", 32'(n0), 32'd128);
        idle(); wait_idle();
        ren = 1; raddr = 7'h10; tick();
        check("cleared_10", 32'(dout_o[0]), 32'h00);
        raddr = 7'h30; tick();
        check("cleared_30", 32'(dout_o[0]), 32'h00);
        idle();

        // Two-cycle latency ordering and reset flush.
        for (int i = 1; i <= 3; i++) begin
            wen = 1; waddr = 7'(i); din = 8'(8'hA0 + i); tick();
        end
        wen = 0;
        ren = 1; raddr = 7'h01; tick();
        raddr = 7'h02; tick();
        check("lat2_first", 32'(dout_o[1]), 32'hA1);
        raddr = 7'h03; tick();
        check("lat2_second", 32'(dout_o[1]), 32'hA2);
        ren = 0; rst = 1; tick();
        check("lat2_rst_valid", 32'(valid_o[1]), 32'd0);
        rst = 0; tick();
        check("lat2_rst_valid2", 32'(valid_o[1]), 32'd0);
        wait_idle();

        // Random traffic.
        for (int i = 0; i < 3000; i++) begin
            rst   = ($urandom_range(0, 599) == 0);
            clr   = ($urandom_range(0, 249) == 0);
            ren   = 1'($urandom_range(0, 1));
            wen   = 1'($urandom_range(0, 1));
            raddr = ($urandom_range(0, 3) == 0) ? 7'($urandom_range(0, 127)) : 7'($urandom_range(0, 7));
            waddr = ($urandom_range(0, 3) == 0) ? 7'($urandom_range(0, 127)) : 7'($urandom_range(0, 7));
            din   = 8'($urandom_range(0, 255));
            tick();
        end
        idle(); tick(); tick();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
